wb_stage: RTL and testbench

Registered MEM/WB pipeline stage and writeback unit for the pipelined core, replacing the purely combinational writeback mux. It captures memory-stage results into a pipeline register with stall/flush control. It aligns and sign/zero-extends sub-word loads and selects among four writeback sources. It also drives the register-file write port and forwarding source, flags misaligned loads, and counts retired register writes.

---
 rtl/wb_stage.sv | 174 +++++++++++++++++
 tb/tb_wb_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   Registered MEM/WB pipeline stage and writeback unit. It aligns and extends
//   sub-word loads, selects one of four writeback sources, and registers the
//   result together with the register-file write controls. The stage supports
//   stall and flush, flags misaligned loads, and counts retired register writes.
//
// Parameters
//   DATA_W  datapath width (32 or 64)
//   REG_AW  register address width
//   CNT_W   retire counter width
//   LO_W    byte-offset width, derived from DATA_W
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset, clears every output
//   stall            in   hold the pipeline register
//   flush            in   load a bubble
//   in_valid         in   memory stage holds a real instruction
//   in_reg_write     in   instruction writes a register
//   in_wb_sel        in   0=ALU 1=load 2=PC+4 3=immediate
//   in_mem_size      in   0=byte 1=half 2=word 3=double
//   in_mem_unsigned  in   1=zero-extend load, 0=sign-extend
//   in_addr_lo       in   low address bits of the load
//   in_alu_result, in_mem_rdata, in_pc_plus4, in_imm   in  source operands
//   in_write_reg     in   destination register
//   wb_valid         out  registered entry is real
//   wb_reg_write     out  register-file write enable
//   wb_write_reg     out  register-file write address
//   wb_data          out  register-file write data / forwarding value
//   misalign_err     out  registered entry was a misaligned load
//   retire_count     out  number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    localparam int LO_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_unsigned,
    input  logic [LO_W-1:0]   in_addr_lo,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    input  logic [DATA_W-1:0] in_pc_plus4,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_write_reg,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  retire_count
);

    // Byte offset of the selected lane: the address rounded down to the
    // access size. Word on a 32-bit bus and double always start at byte 0.
    function automatic logic [LO_W-1:0] lane_offset(input logic [LO_W-1:0] lo,
                                                     input logic [1:0]      size);
        case (size)
            2'd0:    return lo;
            2'd1:    return lo & ~LO_W'(1);
            2'd2:    return lo & ~LO_W'(3);
            default: return '0;
        endcase
    endfunction

    // A double access on a 32-bit bus can never be aligned.
    function automatic logic is_misaligned(input logic [LO_W-1:0] lo,
                                           input logic [1:0]      size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            2'd2:    return |(lo & LO_W'(3));
            default: return (DATA_W == 32) ? 1'b1 : |lo;
        endcase
    endfunction

    // Right-justified field extended to DATA_W: push the field to the top of
    // the word, then shift it back arithmetically or logically.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] field,
                                                      input logic [1:0]        size,
                                                      input logic              uns);
        int unsigned              sh;
        logic [DATA_W-1:0]        up;
        logic signed [DATA_W-1:0] sup;
        case (size)
            2'd0:    sh = DATA_W - 8;
            2'd1:    sh = DATA_W - 16;
            2'd2:    sh = DATA_W - 32;
            default: sh = 0;
        endcase
        up  = field << sh;
        sup = up;
        return uns ? (up >> sh) : $unsigned(sup >>> sh);
    endfunction

    logic [LO_W+2:0]   w_shift;
    logic [DATA_W-1:0] w_field;
    logic [DATA_W-1:0] w_load;
    logic              w_misalign;
    logic [DATA_W-1:0] w_next_data;
    logic              w_next_rw;
    logic              w_load_en;

    logic              r_valid;
    logic              r_reg_write;
    logic [REG_AW-1:0] r_write_reg;
    logic [DATA_W-1:0] r_data;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_retire_cnt;

    assign w_shift    = {lane_offset(in_addr_lo, in_mem_size), 3'b000};
    assign w_field    = in_mem_rdata >> w_shift;
    assign w_load     = extend_load(w_field, in_mem_size, in_mem_unsigned);
    assign w_misalign = (in_wb_sel == 2'd1) && is_misaligned(in_addr_lo, in_mem_size);

    always_comb begin
        w_next_data = in_alu_result;
        case (in_wb_sel)
            2'd0:    w_next_data = in_alu_result;
            2'd1:    w_next_data = w_load;
            2'd2:    w_next_data = in_pc_plus4;
            default: w_next_data = in_imm;
        endcase
    end

    // r0 is hard-wired zero, so writes to it never reach the register file.
    assign w_next_rw = in_valid && in_reg_write && (in_write_reg != '0) && !w_misalign;
    assign w_load_en = !flush && !stall;

    // ---- MEM/WB pipeline register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_data       <= '0;
            r_misalign   <= 1'b0;
            r_retire_cnt <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_data       <= '0;
            r_misalign   <= 1'b0;
        end else if (w_load_en) begin
            r_valid      <= in_valid;
            r_reg_write  <= w_next_rw;
            r_write_reg  <= in_write_reg;
            r_data       <= w_next_data;
            r_misalign   <= in_valid && w_misalign;
            // Counted only on the loading edge, so a held entry retires once.
            if (w_next_rw) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_valid     = r_valid;
    assign wb_reg_write = r_reg_write;
    assign wb_write_reg = r_write_reg;
    assign wb_data      = r_data;
    assign misalign_err = r_misalign;
    assign retire_count = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
//   Scoreboard bench for wb_stage. Two instances: a 32-bit datapath with a
//   4-bit retire counter (wrap case) and a 64-bit datapath. Each driven cycle
//   pushes the model's expected register state; the entry is popped and
//   compared one clock later.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    typedef struct {
        logic        rst_n, stall, flush, valid, rw, uns;
        logic [1:0]  sel, size;
        logic [2:0]  lo;
        logic [4:0]  wr;
        logic [63:0] alu, mem, pc, imm;
    } stim_t;

    typedef struct {
        logic        valid, rw, err;
        logic [4:0]  wreg;
        logic [63:0] data;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        rst_n0, stall0, flush0, valid0, rw0, uns0;
    logic [1:0]  sel0, size0, lo0;
    logic [4:0]  wr0;
    logic [31:0] alu0, mem0, pc0, imm0;
    logic        wb_valid0, wb_rw0, err0;
    logic [4:0]  wb_reg0;
    logic [31:0] wb_data0;
    logic [3:0]  cnt0;

    // 64-bit instance signals
    logic        rst_n1, stall1, flush1, valid1, rw1, uns1;
    logic [1:0]  sel1, size1;
    logic [2:0]  lo1;
    logic [4:0]  wr1;
    logic [63:0] alu1, mem1, pc1, imm1;
    logic        wb_valid1, wb_rw1, err1;
    logic [4:0]  wb_reg1;
    logic [63:0] wb_data1;
    logic [31:0] cnt1;

    wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n0), .stall(stall0), .flush(flush0),
        .in_valid(valid0), .in_reg_write(rw0), .in_wb_sel(sel0),
        .in_mem_size(size0), .in_mem_unsigned(uns0), .in_addr_lo(lo0),
        .in_alu_result(alu0), .in_mem_rdata(mem0), .in_pc_plus4(pc0),
        .in_imm(imm0), .in_write_reg(wr0),
        .wb_valid(wb_valid0), .wb_reg_write(wb_rw0), .wb_write_reg(wb_reg0),
        .wb_data(wb_data0), .misalign_err(err0), .retire_count(cnt0)
    );

    wb_stage #(.DATA_W(64), .REG_AW(5), .CNT_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n1), .stall(stall1), .flush(flush1),
        .in_valid(valid1), .in_reg_write(rw1), .in_wb_sel(sel1),
        .in_mem_size(size1), .in_mem_unsigned(uns1), .in_addr_lo(lo1),
        .in_alu_result(alu1), .in_mem_rdata(mem1), .in_pc_plus4(pc1),
        .in_imm(imm1), .in_write_reg(wr1),
        .wb_valid(wb_valid1), .wb_reg_write(wb_rw1), .wb_write_reg(wb_reg1),
        .wb_data(wb_data1), .misalign_err(err1), .retire_count(cnt1)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t m0, m1;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic mdl_misal(input int dw, input logic [1:0] size, input int lo);
        int nb;
        nb = 1 << size;
        if (size == 2'd3 && dw == 32) return 1'b1;
        return (lo % nb) != 0;
    endfunction

    function automatic logic [63:0] mdl_load(input int dw, input logic [63:0] rd,
                                             input logic [1:0] size, input logic uns, input int lo);
        logic [63:0] f;
        int nb, base;
        nb = 1 << size;
        f  = '0;
        if (nb * 8 >= dw) begin
            for (int i = 0; i < dw; i++) f[i] = rd[i];
            return f;
        end
        base = (lo / nb) * nb;
        for (int i = 0; i < nb * 8; i++) f[i] = rd[base * 8 + i];
        if (!uns && f[nb * 8 - 1])
            for (int i = nb * 8; i < dw; i++) f[i] = 1'b1;
        return f;
    endfunction

    task automatic model(input int d, input stim_t s);
        exp_t        e;
        int          dw, lo;
        logic        mis, nrw;
        logic [63:0] nd;
        e  = (d == 0) ? m0 : m1;
        dw = (d == 0) ? 32 : 64;
        lo = (d == 0) ? int'(s.lo[1:0]) : int'(s.lo);
        if (!s.rst_n) begin
            e = '{valid: 1'b0, rw: 1'b0, err: 1'b0, wreg: 5'd0, data: 64'd0, cnt: 32'd0};
        end else if (s.flush) begin
            e.valid = 1'b0; e.rw = 1'b0; e.err = 1'b0; e.wreg = 5'd0; e.data = 64'd0;
        end else if (!s.stall) begin
            mis = (s.sel == 2'd1) && mdl_misal(dw, s.size, lo);
            case (s.sel)
                2'd0:    nd = s.alu;
                2'd1:    nd = mdl_load(dw, s.mem, s.size, s.uns, lo);
                2'd2:    nd = s.pc;
                default: nd = s.imm;
            endcase
            if (dw == 32) nd[63:32] = 32'd0;
            nrw     = s.valid && s.rw && (s.wr != 5'd0) && !mis;
            e.valid = s.valid;
            e.rw    = nrw;
            e.wreg  = s.wr;
            e.data  = nd;
            e.err   = s.valid && mis;
            if (nrw) e.cnt = (e.cnt + 32'd1) & ((d == 0) ? 32'hF : 32'hFFFF_FFFF);
        end
        if (d == 0) begin m0 = e; q0.push_back(e); end
        else        begin m1 = e; q1.push_back(e); end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rst_n = ($urandom_range(0, 19) != 0);
        s.stall = ($urandom_range(0, 3) == 0);
        s.flush = ($urandom_range(0, 5) == 0);
        s.valid = ($urandom_range(0, 4) != 0);
        s.rw    = ($urandom_range(0, 3) != 0);
        s.uns   = 1'($urandom);
        s.sel   = 2'($urandom);
        s.size  = 2'($urandom);
        s.lo    = 3'($urandom);
        s.wr    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        s.alu = r64(); s.mem = r64(); s.pc = r64(); s.imm = r64();
        return s;
    endfunction

    function automatic stim_t op(input logic [1:0] sel, input logic [1:0] size, input logic uns,
                                 input logic [2:0] lo, input logic [4:0] wr, input logic [63:0] val);
        stim_t s;
        s = rnd_stim();
        s.rst_n = 1'b1; s.stall = 1'b0; s.flush = 1'b0;
        s.valid = 1'b1; s.rw = 1'b1;
        s.sel = sel; s.size = size; s.uns = uns; s.lo = lo; s.wr = wr;
        case (sel)
            2'd0:    s.alu = val;
            2'd1:    s.mem = val;
            2'd2:    s.pc  = val;
            default: s.imm = val;
        endcase
        return s;
    endfunction

    task automatic drive(input int d, input stim_t s);
        if (d == 0) begin
            rst_n0 = s.rst_n; stall0 = s.stall; flush0 = s.flush; valid0 = s.valid;
            rw0 = s.rw; uns0 = s.uns; sel0 = s.sel; size0 = s.size; lo0 = s.lo[1:0];
            wr0 = s.wr; alu0 = s.alu[31:0]; mem0 = s.mem[31:0]; pc0 = s.pc[31:0];
            imm0 = s.imm[31:0];
            rst_n1 = 1'b1; stall1 = 1'b1; flush1 = 1'b0;
        end else begin
            rst_n1 = s.rst_n; stall1 = s.stall; flush1 = s.flush; valid1 = s.valid;
            rw1 = s.rw; uns1 = s.uns; sel1 = s.sel; size1 = s.size; lo1 = s.lo;
            wr1 = s.wr; alu1 = s.alu; mem1 = s.mem; pc1 = s.pc; imm1 = s.imm;
            rst_n0 = 1'b1; stall0 = 1'b1; flush0 = 1'b0;
        end
    endtask

    task automatic compare(input int d);
        exp_t e;
        if (d == 0) begin
            check_val("d0_sb_depth", 64'(q0.size()), 64'd1);
            if (q0.size() == 0) return;
            e = q0.pop_front();
            check_val("d0_valid", wb_valid0, e.valid);
            check_val("d0_reg_write", wb_rw0, e.rw);
            check_val("d0_write_reg", wb_reg0, e.wreg);
            check_val("d0_data", wb_data0, e.data);
            check_val("d0_misalign", err0, e.err);
            check_val("d0_retire", cnt0, e.cnt);
        end else begin
            check_val("d1_sb_depth", 64'(q1.size()), 64'd1);
            if (q1.size() == 0) return;
            e = q1.pop_front();
            check_val("d1_valid", wb_valid1, e.valid);
            check_val("d1_reg_write", wb_rw1, e.rw);
            check_val("d1_write_reg", wb_reg1, e.wreg);
            check_val("d1_data", wb_data1, e.data);
            check_val("d1_misalign", err1, e.err);
            check_val("d1_retire", cnt1, e.cnt);
        end
    endtask

    // One clock: drive, predict, then compare 1 ns after the edge.
    task automatic cyc(input int d, input stim_t s);
        drive(d, s);
        model(d, s);
        @(posedge clk);
        #1;
        compare(d);
    endtask

    initial begin
        stim_t s;
        drive(1, rnd_stim());
        drive(0, rnd_stim());
        rst_n1 = 1'b1; stall1 = 1'b1; flush1 = 1'b0;

        // ---------------- 32-bit instance ----------------
        for (int i = 0; i < 2; i++) begin
            s = rnd_stim(); s.rst_n = 1'b0;
            cyc(0, s);
        end
        check_val("rst_valid", wb_valid0, 1'b0);
        check_val("rst_data", wb_data0, 64'd0);
        check_val("rst_count", cnt0, 64'd0);

        cyc(0, op(2'd0, 2'd2, 1'b0, 3'd0, 5'd5, 64'h1234_5678));
        check_val("first_alu_data", wb_data0, 64'h1234_5678);
        check_val("first_alu_count", cnt0, 64'd1);

        cyc(0, op(2'd1, 2'd0, 1'b0, 3'd3, 5'd6, 64'h80FF_7F01));
        check_val("lb_lo3", wb_data0, 64'hFFFF_FF80);
        cyc(0, op(2'd1, 2'd0, 1'b1, 3'd1, 5'd6, 64'h80FF_7F01));
        check_val("lbu_lo1", wb_data0, 64'h0000_007F);
        cyc(0, op(2'd1, 2'd1, 1'b0, 3'd2, 5'd6, 64'h80FF_7F01));
        check_val("lh_lo2", wb_data0, 64'hFFFF_80FF);
        cyc(0, op(2'd1, 2'd1, 1'b1, 3'd0, 5'd6, 64'h80FF_7F01));
        check_val("lhu_lo0", wb_data0, 64'h0000_7F01);

        cyc(0, op(2'd2, 2'd2, 1'b0, 3'd0, 5'd1, 64'h0000_0104));
        check_val("link_data", wb_data0, 64'h104);
        check_val("link_write", wb_rw0, 1'b1);
        cyc(0, op(2'd3, 2'd2, 1'b0, 3'd0, 5'd0, 64'hABCD_0000));
        check_val("r0_valid", wb_valid0, 1'b1);
        check_val("r0_write", wb_rw0, 1'b0);
        check_val("r0_count", cnt0, 64'd6);

        cyc(0, op(2'd1, 2'd2, 1'b0, 3'd2, 5'd9, 64'h1111_2222));
        check_val("lw_mis_err", err0, 1'b1);
        check_val("lw_mis_write", wb_rw0, 1'b0);
        cyc(0, op(2'd1, 2'd1, 1'b0, 3'd1, 5'd9, 64'h1111_2222));
        check_val("lh_mis_err", err0, 1'b1);
        check_val("lh_mis_count", cnt0, 64'd6);

        cyc(0, op(2'd0, 2'd2, 1'b0, 3'd0, 5'd7, 64'hAAAA_5555));
        for (int i = 0; i < 3; i++) begin
            s = op(2'd0, 2'd2, 1'b0, 3'd0, 5'(10 + i), 64'(32'h100 + i));
            s.stall = 1'b1;
            cyc(0, s);
            check_val("stall_data", wb_data0, 64'hAAAA_5555);
            check_val("stall_write", wb_rw0, 1'b1);
            check_val("stall_count", cnt0, 64'd7);
        end
        s = op(2'd0, 2'd2, 1'b0, 3'd0, 5'd12, 64'h0BAD);
        s.stall = 1'b1; s.flush = 1'b1;
        cyc(0, s);
        check_val("flush_valid", wb_valid0, 1'b0);
        check_val("flush_count", cnt0, 64'd7);

        s = rnd_stim(); s.rst_n = 1'b0;
        cyc(0, s);
        for (int i = 0; i < 17; i++)
            cyc(0, op(2'd0, 2'd2, 1'b0, 3'd0, 5'(1 + i), r64()));
        check_val("wrap_count", cnt0, 64'd1);

        for (int i = 0; i < 80; i++) cyc(0, rnd_stim());

        // ---------------- 64-bit instance ----------------
        s = rnd_stim(); s.rst_n = 1'b0;
        cyc(1, s);
        check_val("rst64_count", cnt1, 64'd0);
        cyc(1, op(2'd1, 2'd3, 1'b0, 3'd0, 5'd3, 64'h8000_0000_0000_0001));
        check_val("ld_data", wb_data1, 64'h8000_0000_0000_0001);
        cyc(1, op(2'd1, 2'd2, 1'b0, 3'd4, 5'd3, 64'h8000_0000_0000_0001));
        check_val("lw_lo4", wb_data1, 64'hFFFF_FFFF_8000_0000);
        cyc(1, op(2'd1, 2'd1, 1'b1, 3'd6, 5'd4, 64'hBEEF_0000_0000_0000));
        check_val("lhu_lo6", wb_data1, 64'h0000_0000_0000_BEEF);
        cyc(1, op(2'd1, 2'd3, 1'b0, 3'd4, 5'd4, 64'h1));
        check_val("ld_mis_err", err1, 1'b1);
        check_val("d64_count", cnt1, 64'd3);

        for (int i = 0; i < 80; i++) cyc(1, rnd_stim());

        check_val("q0_drained", 64'(q0.size()), 64'd0);
        check_val("q1_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
